// File: rtl/maze_explorer_ctrl_if.sv
// Bus between the maze search controller and its location-step datapath / maze memory.
// The controller takes the master modport; the datapath and memory side takes slave.
interface maze_explorer_ctrl_if;
  logic [7:0] nxtLoc;
  logic       cntReach;
  logic       memRd;
  logic [7:0] memAdr;
  logic       memWr;
  logic       memWrData;
  logic [1:0] dir;
  logic       rgLd;

  modport master (
    input  nxtLoc, cntReach, memRd,
    output memAdr, memWr, memWrData, dir, rgLd
  );

  modport slave (
    output nxtLoc, cntReach, memRd,
    input  memAdr, memWr, memWrData, dir, rgLd
  );
endinterface

// File: rtl/maze_explorer_ctrl.sv
// Depth-first maze search controller with a direction stack for backtracking on a 16x16 grid.
// Define MAZE_STATS_EN to add the btCnt/tryCnt statistics outputs.
module maze_explorer_ctrl #(
  parameter int         DEPTH  = 256,
  parameter logic [7:0] START  = 8'h00,
  parameter logic [7:0] TARGET = 8'hFF,
  localparam int        PW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  maze_explorer_ctrl_if.master bus,
  output logic [7:0]           currLoc,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [PW-1:0]        pathLen
`ifdef MAZE_STATS_EN
  ,
  output logic [15:0]          btCnt,
  output logic [15:0]          tryCnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TRY,
    S_BACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t     state;
  logic [1:0] dir_reg;
  logic [1:0] stack_mem [DEPTH];
  logic [1:0] top_dir;
  logic       stack_full;
  logic       stack_empty;
  logic       legal;
  logic       push;
  logic       pop;
  logic       start_accept;

  assign stack_full   = (pathLen == PW'(DEPTH));
  assign stack_empty  = (pathLen == '0);
  assign top_dir      = stack_empty ? 2'b00 : stack_mem[AW'(pathLen - 1'b1)];
  assign legal        = !bus.cntReach && !bus.memRd;
  assign push         = (state == S_TRY) && legal && !stack_full;
  assign pop          = (state == S_BACK) && !stack_empty;
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

  assign bus.memWrData = 1'b1;

  // Probe address, write strobe and step direction react to memRd/nxtLoc in the same cycle,
  // so that one direction is tried per clock.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    bus.memAdr = currLoc;
    bus.dir    = dir_reg;
    bus.memWr  = 1'b0;
    bus.rgLd   = 1'b0;
    case (state)
      S_INIT: begin
        bus.memAdr = START;
        bus.memWr  = !bus.memRd;
      end
      S_TRY: begin
        bus.memAdr = bus.nxtLoc;
        bus.memWr  = push;
        bus.rgLd   = push;
      end
      S_BACK: begin
        bus.dir  = ~top_dir;
        bus.rgLd = pop;
      end
      default: ;
    endcase
  end

  // NOTE: the stack array has no reset; pathLen alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack_mem[AW'(pathLen)] <= dir_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      currLoc <= START;
      dir_reg <= 2'b00;
      pathLen <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          // A new run clears the stack and the sticky result flags on entry to INIT.
          if (start_accept) begin
            state   <= S_INIT;
            busy    <= 1'b1;
            done    <= 1'b0;
            fail    <= 1'b0;
            pathLen <= '0;
          end
        end
        S_INIT: begin
          currLoc <= START;
          dir_reg <= 2'b00;
          if (bus.memRd) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else if (START == TARGET) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_TRY;
          end
        end
        S_TRY: begin
          if (legal) begin
            if (stack_full) begin
              state <= S_FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else begin
              pathLen <= pathLen + 1'b1;
              currLoc <= bus.nxtLoc;
              dir_reg <= 2'b00;
              if (bus.nxtLoc == TARGET) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end else if (dir_reg == 2'b11) begin
            state <= S_BACK;
          end else begin
            dir_reg <= dir_reg + 2'd1;
          end
        end
        S_BACK: begin
          if (stack_empty) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            pathLen <= pathLen - 1'b1;
            currLoc <= bus.nxtLoc;
            // A popped 11 means every direction of the parent cell is exhausted too.
            if (top_dir != 2'b11) begin
              dir_reg <= top_dir + 2'd1;
              state   <= S_TRY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MAZE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      btCnt  <= '0;
      tryCnt <= '0;
    end else begin
      if (pop && (btCnt != 16'hFFFF)) btCnt <= btCnt + 16'd1;
      if ((state == S_TRY) && (tryCnt != 16'hFFFF)) tryCnt <= tryCnt + 16'd1;
    end
  end
`endif

endmodule
